rx: RTL and testbench
=====================

RX -- requirements
Module: rx

Interface
REQ-001 SHALL have parameter CLK_BAUD_RATIO, default 25, clock cycles per bit period; legal values are 4 or more.
REQ-002 SHALL have parameter DATA_SIZE, default 8, number of data bits per frame.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port rx_in, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port ready_in, input, 1 bit: the consumer accepts data_out.
REQ-007 SHALL have port data_out, output, DATA_SIZE bits: received word.
REQ-008 SHALL have port valid_out, output, 1 bit: data_out holds an unconsumed word.
REQ-009 SHALL have port framing_err_out, output, 1 bit: one-cycle pulse when the stop bit samples 0.
REQ-010 SHALL have port overrun_out, output, 1 bit: one-cycle pulse when a completed word is dropped.

Function
REQ-011 SHALL pass rx_in through a 2-flop synchronizer; rx_s denotes the synchronizer output.
REQ-012 SHALL implement the state machine IDLE -> START -> DATA -> STOP -> IDLE.
REQ-013 Frame format SHALL be: start bit 0, then DATA_SIZE data bits LSB first, then stop bit 1.
REQ-014 IDLE SHALL wait for rx_s==0; that cycle is t0, and the bit counter and baud counter clear.
REQ-015 START SHALL sample rx_s at t0+H, where H = floor(CLK_BAUD_RATIO/2).
REQ-016 If the start sample is 1, the block SHALL return to IDLE as a glitch, with no flags and no output.
REQ-017 Data bit i SHALL be sampled at t0+H+(i+1)*CLK_BAUD_RATIO, for i = 0..DATA_SIZE-1.
REQ-018 STOP SHALL sample at t0+H+(DATA_SIZE+1)*CLK_BAUD_RATIO, and the block SHALL enter IDLE on the next cycle.
REQ-019 If the stop sample is 0: framing_err_out SHALL pulse on the next cycle; the word SHALL be discarded; data_out and valid_out SHALL be unchanged.
REQ-020 Good stop, valid_out==0: data_out SHALL load the word and valid_out SHALL assert on the next cycle.
REQ-021 valid_out SHALL remain high, with data_out stable, until a cycle with valid_out && ready_in; valid_out SHALL clear on the following cycle.
REQ-022 Good stop, valid_out==1, ready_in==0: the new word SHALL be dropped, overrun_out SHALL pulse, and data_out SHALL stay unchanged.
REQ-023 Good stop in the same cycle as valid_out && ready_in: the new word SHALL load, valid_out SHALL stay 1, and no overrun SHALL be flagged.
REQ-024 The baud counter SHALL wrap at CLK_BAUD_RATIO-1 to 0, and the bit counter SHALL be wide enough for DATA_SIZE+2 values.
REQ-025 rx_in activity in the DATA and STOP states SHALL affect only the sample instants; a falling edge SHALL never restart a frame outside IDLE.

Reset
REQ-026 On rst_in high, asynchronously: state IDLE, counters 0, synchronizer flops 1, data_out 0, valid_out 0, framing_err_out 0, overrun_out 0.
REQ-027 Reset mid-frame SHALL abandon the frame; the first falling edge after release SHALL start a fresh frame.

Configuration
REQ-028 With macro RX_MAJORITY_EN defined, each bit decision SHALL be the 2-of-3 majority of rx_s sampled at the nominal instant -1, 0 and +1.
REQ-029 With RX_MAJORITY_EN, all decision instants and downstream outputs SHALL occur 1 cycle later than in REQ-015 to REQ-020.
REQ-030 Without RX_MAJORITY_EN, each bit decision SHALL be the single sample taken at the nominal instant.

Structure
REQ-031 Package uart_pkg SHALL hold the rx state enum typedef and the default CLK_BAUD_RATIO and DATA_SIZE constants.
REQ-032 The 2-flop synchronizer SHALL be the sub-module sync2, 1-bit wide, with reset value 1.

Verification
REQ-033 R=25, D=8, ready_in=1, frame 0xA5 -> data_out=0xA5, valid_out high exactly 1 cycle, both flags 0.
REQ-034 rx_in low for 5 cycles then high -> no valid_out, no flags, state back in IDLE; a following 0x3C frame is received correctly.
REQ-035 Frame 0x3C with stop bit 0 -> framing_err_out 1-cycle pulse, valid_out stays 0.
REQ-036 ready_in=0, back-to-back frames 0x11 then 0x22 -> data_out=0x11 held, overrun_out pulses at the second stop; ready_in=1 -> 0x11 consumed, valid_out drops.
REQ-037 rst_in pulsed during data bit 3 of frame 0xFF -> all outputs 0; the next frame 0x5A yields data_out=0x5A.
REQ-038 Frame 0xFF with a 1-cycle low glitch at the bit-0 mid-instant -> 0xFF with RX_MAJORITY_EN, 0xFE without.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver types and default frame parameters.
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned RX_CLK_BAUD_RATIO_DEF = 25;
    localparam int unsigned RX_DATA_SIZE_DEF      = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // 2-of-3 vote used when bit decisions are majority-filtered.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to 1.
`timescale 1ns/1ps
module sync2 (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic q_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/rx.sv
// UART receiver: start/data/stop framing, one-word output buffer with valid/ready.
// Define RX_MAJORITY_EN to make each bit decision a 2-of-3 vote (decisions one cycle later).
`timescale 1ns/1ps
module rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_BAUD_RATIO = RX_CLK_BAUD_RATIO_DEF,
    parameter int unsigned DATA_SIZE      = RX_DATA_SIZE_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rx_in,
    input  logic                 ready_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 framing_err_out,
    output logic                 overrun_out
);

    localparam int unsigned BAUD_W = (CLK_BAUD_RATIO > 1) ? $clog2(CLK_BAUD_RATIO) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_SIZE + 2);
    localparam int unsigned HALF   = CLK_BAUD_RATIO / 2;
`ifdef RX_MAJORITY_EN
    localparam int unsigned SAMPLE_AT = HALF;
`else
    localparam int unsigned SAMPLE_AT = HALF - 1;
`endif

    logic rx_s;

    sync2 u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (rx_in),
        .q_out  (rx_s)
    );

    rx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 sample_c, bit_c, stop_good_c, stop_bad_c, consume_c;

`ifdef RX_MAJORITY_EN
    // Two previous rx_s values, so the vote covers nominal-1, nominal, nominal+1.
    logic hist1_q, hist1_d, hist2_q, hist2_d;

    always_comb begin
        hist1_d = rx_s;
        hist2_d = hist1_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
        end
    end

    assign bit_c = maj3(hist2_q, hist1_q, rx_s);
`else
    assign bit_c = rx_s;
`endif

    // Baud counter reads k-1 in cycle t0+k, so every bit centre lands on the same count.
    assign sample_c = (baud_q == BAUD_W'(SAMPLE_AT));

    always_comb begin
        state_d     = state_q;
        baud_d      = (baud_q == BAUD_W'(CLK_BAUD_RATIO - 1)) ? '0 : baud_q + BAUD_W'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        stop_good_c = 1'b0;
        stop_bad_c  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (sample_c) state_d = bit_c ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (sample_c) begin
                    shift_d = (shift_q >> 1) | (DATA_SIZE'(bit_c) << (DATA_SIZE - 1));
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_SIZE - 1)) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (sample_c) begin
                    state_d     = RX_IDLE;
                    stop_good_c = bit_c;
                    stop_bad_c  = !bit_c;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // A word arriving while the buffer is being consumed replaces it without overrun.
    always_comb begin
        consume_c = valid_q && ready_in;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = stop_bad_c;
        ovr_d     = 1'b0;
        if (consume_c) valid_d = 1'b0;
        if (stop_good_c) begin
            if (!valid_q || consume_c) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= RX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out        = data_q;
    assign valid_out       = valid_q;
    assign framing_err_out = ferr_q;
    assign overrun_out     = ovr_q;

endmodule

// File: tb/tb_rx.sv
// Self-checking bench for rx: directed frame table, corner sequences, random frames vs. a cycle-indexed model.
`timescale 1ns/1ps
module tb_rx;

    localparam int R = 25;
    localparam int D = 8;
    localparam int H = R / 2;
`ifdef RX_MAJORITY_EN
    localparam int MAJ = 1;
    localparam logic [D-1:0] GLITCH_EXP = 8'hFF;
`else
    localparam int MAJ = 0;
    localparam logic [D-1:0] GLITCH_EXP = 8'hFE;
`endif

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         rx_in;
    logic         ready_in;
    logic [D-1:0] data_out;
    logic         valid_out;
    logic         framing_err_out;
    logic         overrun_out;

    rx #(.CLK_BAUD_RATIO(R), .DATA_SIZE(D)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rx_in           (rx_in),
        .ready_in        (ready_in),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .framing_err_out (framing_err_out),
        .overrun_out     (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    int n_vcyc, n_ferr, n_ovr;

    // Reference model: rx_s history indexed by absolute cycle; frame decoded from t0 arithmetic.
    bit           hist [int];
    bit           m1 = 1'b1, m2 = 1'b1, busy = 1'b0;
    int           t0 = 0, cyc = 0;
    logic [D-1:0] exp_data = '0, mword;
    logic         exp_valid = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0;
    bit           good, bad, consume;

    typedef struct {
        logic [D-1:0] data;
        logic         stop;
        logic         ready;
        int           glitch;
        logic [D-1:0] exp_data;
        int           exp_vcyc;
        int           exp_ferr;
        int           exp_ovr;
    } vec_t;
    vec_t vecs [4];

    function automatic bit decide(input int c);
        if (MAJ != 0)
            return (hist[c-1] & hist[c]) | (hist[c-1] & hist[c+1]) | (hist[c] & hist[c+1]);
        return hist[c];
    endfunction

    task automatic model_update();
        if (rst_in) begin
            m1 = 1'b1; m2 = 1'b1; busy = 1'b0;
            exp_data = '0; exp_valid = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
        end else begin
            hist[cyc] = m2;
            good = 1'b0;
            bad  = 1'b0;
            if (!busy) begin
                if (!m2) begin busy = 1'b1; t0 = cyc; end
            end else if (cyc == t0 + H + MAJ) begin
                if (decide(t0 + H)) busy = 1'b0;
            end else if (cyc == t0 + H + (D + 1) * R + MAJ) begin
                busy = 1'b0;
                for (int i = 0; i < D; i++) mword[i] = decide(t0 + H + (i + 1) * R);
                if (decide(t0 + H + (D + 1) * R)) good = 1'b1; else bad = 1'b1;
            end
            consume  = exp_valid && ready_in;
            exp_ferr = bad;
            exp_ovr  = 1'b0;
            if (good) begin
                if (!exp_valid || consume) begin exp_data = mword; exp_valid = 1'b1; end
                else exp_ovr = 1'b1;
            end else if (consume) begin
                exp_valid = 1'b0;
            end
            m2 = m1;
            m1 = rx_in;
            cyc++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One cycle: compare at negedge, advance the model at posedge, return just after it.
    task automatic step();
        @(negedge clk_in);
        if (rst_in)
            check("reset_outputs", 32'({data_out, valid_out, framing_err_out, overrun_out}), 32'(0));
        else
            check("cycle_model", 32'({data_out, valid_out, framing_err_out, overrun_out}),
                  32'({exp_data, exp_valid, exp_ferr, exp_ovr}));
        n_vcyc += int'(valid_out);
        n_ferr += int'(framing_err_out);
        n_ovr  += int'(overrun_out);
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_counts();
        n_vcyc = 0; n_ferr = 0; n_ovr = 0;
    endtask

    // Line index j maps to bit j/R (0 = start, D+1 = stop); glitch forces one low cycle.
    task automatic send_frame(input logic [D-1:0] data, input logic stop, input int glitch,
                              input int abort_at, input bit rand_rdy);
        logic [D+1:0] bits;
        bits = {stop, data, 1'b0};
        for (int j = 0; j < (D + 2) * R; j++) begin
            if (j == abort_at) begin
                rx_in  = 1'b1;
                rst_in = 1'b1;
                step();
                step();
                rst_in = 1'b0;
                return;
            end
            rx_in = (j == glitch) ? 1'b0 : bits[j / R];
            if (rand_rdy) ready_in = 1'($urandom_range(0, 1));
            step();
        end
        rx_in = 1'b1;
    endtask

    initial begin
        rst_in   = 1'b1;
        rx_in    = 1'b1;
        ready_in = 1'b1;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, -1,    8'hA5,      1, 0, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, -1,    8'hA5,      0, 1, 0};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, -1,    8'h3C,      1, 0, 0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, H + R, GLITCH_EXP, 1, 0, 0};

        idle(3);
        rst_in = 1'b0;
        idle(5);
        check("reset_valid", 32'(valid_out), 32'(0));
        check("reset_data", 32'(data_out), 32'(0));

        foreach (vecs[v]) begin
            ready_in = vecs[v].ready;
            clear_counts();
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].glitch, -1, 1'b0);
            idle(2 * R);
            check($sformatf("vec%0d_data", v), 32'(data_out), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_valid_cycles", v), 32'(n_vcyc), 32'(vecs[v].exp_vcyc));
            check($sformatf("vec%0d_ferr", v), 32'(n_ferr), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_ovr", v), 32'(n_ovr), 32'(vecs[v].exp_ovr));
        end

        // Short low pulse on an idle line is rejected; the next frame still decodes.
        clear_counts();
        rx_in = 1'b0;
        idle(5);
        rx_in = 1'b1;
        idle(3 * R);
        check("glitch_no_events", 32'(n_vcyc + n_ferr + n_ovr), 32'(0));
        send_frame(8'h3C, 1'b1, -1, -1, 1'b0);
        idle(2 * R);
        check("glitch_then_frame", 32'(data_out), 32'(8'h3C));
        check("glitch_then_frame_vcyc", 32'(n_vcyc), 32'(1));

        // Back-to-back frames with no consumer: second word is dropped.
        ready_in = 1'b0;
        clear_counts();
        send_frame(8'h11, 1'b1, -1, -1, 1'b0);
        send_frame(8'h22, 1'b1, -1, -1, 1'b0);
        idle(5);
        check("ovr_data_held", 32'(data_out), 32'(8'h11));
        check("ovr_valid_held", 32'(valid_out), 32'(1));
        check("ovr_pulses", 32'(n_ovr), 32'(1));
        ready_in = 1'b1;
        step();
        check("ovr_consumed", 32'(valid_out), 32'(0));
        idle(3);

        // Reset in the middle of data bit 3, then a fresh frame.
        send_frame(8'hFF, 1'b1, -1, 4 * R + H, 1'b0);
        check("midreset_data", 32'(data_out), 32'(0));
        check("midreset_valid", 32'(valid_out), 32'(0));
        idle(R);
        send_frame(8'h5A, 1'b1, -1, -1, 1'b0);
        idle(2 * R);
        check("after_reset_frame", 32'(data_out), 32'(8'h5A));

        // Random frames, stop errors, consumer back-pressure and idle-line noise.
        for (int k = 0; k < 40; k++) begin
            send_frame(D'($urandom), ($urandom_range(0, 7) != 0), -1, -1, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                rx_in = 1'b0;
                idle($urandom_range(1, R));
                rx_in = 1'b1;
            end
            idle($urandom_range(0, 2 * R));
        end
        ready_in = 1'b1;
        idle(3 * R);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
